// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM arbiter slice.
//   state_e : controller FSM encoding (IDLE, ACCESS, DONE)
//   NCH_MAX : largest supported channel count
//   idx_w() : width of a grant index for n channels (at least 1 bit)
package sram_arb_pkg;

  localparam int NCH_MAX = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// Requester-side bus of the SRAM arbiter: per-channel request/command
// vectors (flattened, channel i at [i*W +: W]) plus shared response.
//   master : the requesters (drive req/write/adr/sel/wdata, see ack/rdata/busy)
//   slave  : the arbiter
// NCH/AW/DW must match the sram_arbiter instance the bus is bound to.
interface sram_arb_if #(
  parameter int NCH = 3,
  parameter int AW  = 18,
  parameter int DW  = 16
);
  localparam int BW = DW / 8;

  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_write;
  logic [NCH*AW-1:0] ch_adr;
  logic [NCH*BW-1:0] ch_sel;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_ack;
  logic [DW-1:0]     rdata;
  logic              busy;

  modport master (
    output ch_req, ch_write, ch_adr, ch_sel, ch_wdata,
    input  ch_ack, rdata, busy
  );

  modport slave (
    input  ch_req, ch_write, ch_adr, ch_sel, ch_wdata,
    output ch_ack, rdata, busy
  );

endinterface

// File: rtl/sram_arb_grant.sv
// Grant selection for the SRAM arbiter.
//   req : per-channel request levels
//   oh  : one-hot grant, idx : grant index, vld : some channel requests
// Build option SRAM_ARB_RR_EN: round-robin starting at a pointer that moves
// past each taken grant (adds clk/rst/adv ports). Without it: fixed
// priority, highest requesting index wins, purely combinational.
module sram_arb_grant import sram_arb_pkg::*; #(
  parameter int NCH = 3,
  parameter int IW  = idx_w(NCH)
) (
`ifdef SRAM_ARB_RR_EN
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,   // grant is being taken this cycle
`endif
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] oh,
  output logic [IW-1:0]  idx,
  output logic           vld
);

`ifdef SRAM_ARB_RR_EN
  logic [IW-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (adv) ptr <= (idx == IW'(NCH - 1)) ? '0 : idx + 1'b1;
  end

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[j]) begin
        vld = 1'b1;
        idx = IW'(j);
      end
    end
    oh = '0;
    if (vld) oh[idx] = 1'b1;
  end
`else
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (req[k]) begin
        vld = 1'b1;
        idx = IW'(k);
      end
    end
    oh = '0;
    if (vld) oh[idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// N-channel arbiter/controller for an external async 16-bit SRAM.
// One access at a time: IDLE (grant, register pins) -> ACCESS (WAIT cycles,
// strobes stable) -> DONE (ack pulse, write data still driven) -> IDLE.
//   clk, rst          : clock, async active-high reset
//   RAMCS/WE/OE/LB/UB : SRAM strobes, active low (CS tied low)
//   ADR, DAT          : registered address, bidirectional data
//   bus (slave)       : requester channels, ack, rdata, busy
// Build option SRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int NCH  = 3,
  parameter int AW   = 18,
  parameter int DW   = 16,
  parameter int WAIT = 1     // 1..15
) (
  input  logic          clk,
  input  logic          rst,
  output logic          RAMCS,
  output logic          RAMWE,
  output logic          RAMOE,
  output logic          RAMLB,
  output logic          RAMUB,
  output logic [AW-1:0] ADR,
  inout  wire  [DW-1:0] DAT,
  sram_arb_if.slave     bus
);

  localparam int BW = DW / 8;
  localparam int IW = idx_w(NCH);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;

  logic [1:0]     state;
  logic [3:0]     cnt;
  logic           drv;
  logic           wr;
  logic [DW-1:0]  wreg;
  logic [NCH-1:0] gsel;

  logic [NCH-1:0] goh;
  logic [IW-1:0]  gidx;
  logic           gvld;

`ifdef SRAM_ARB_RR_EN
  logic adv;
  assign adv = (state == S_IDLE) && gvld;
`endif

  sram_arb_grant #(.NCH(NCH)) u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk (clk),
    .rst (rst),
    .adv (adv),
`endif
    .req (bus.ch_req),
    .oh  (goh),
    .idx (gidx),
    .vld (gvld)
  );

  // Granted channel's command, only sampled in IDLE.
  logic [BW-1:0] g_sel;
  logic          g_wr;
  assign g_sel = bus.ch_sel[gidx*BW +: BW];
  assign g_wr  = bus.ch_write[gidx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      drv        <= 1'b0;
      wr         <= 1'b0;
      wreg       <= '0;
      gsel       <= '0;
      bus.ch_ack <= '0;
      bus.rdata  <= '0;
      RAMWE      <= 1'b1;
      RAMOE      <= 1'b0;
      RAMLB      <= 1'b1;
      RAMUB      <= 1'b1;
      ADR        <= '0;
    end else begin
      case (state)
        S_IDLE: if (gvld) begin
          ADR   <= bus.ch_adr[gidx*AW +: AW];
          // The part has two lane pins: lowest and highest byte select.
          RAMLB <= ~g_sel[0];
          RAMUB <= ~g_sel[BW-1];
          wreg  <= bus.ch_wdata[gidx*DW +: DW];
          wr    <= g_wr;
          drv   <= g_wr;
          RAMOE <= g_wr;     // OE goes high with drv: never both driving
          RAMWE <= ~g_wr;
          cnt   <= 4'(WAIT - 1);
          gsel  <= goh;
          state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            RAMWE      <= 1'b1;
            if (!wr) bus.rdata <= DAT;
            bus.ch_ack <= gsel;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          // drv held through this cycle to cover write hold after WE rise.
          drv        <= 1'b0;
          RAMOE      <= 1'b0;
          RAMLB      <= 1'b1;
          RAMUB      <= 1'b1;
          bus.ch_ack <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign RAMCS    = 1'b0;
  assign DAT      = drv ? wreg : 'z;
  assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: u_dut (WAIT=1) with a byte-lane SRAM
// model, u3 (WAIT=3) with a constant-data SRAM for latency/throughput.
module tb_sram_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 18;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  sram_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();
  sram_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus3 ();

  wire  [DW-1:0] dat, dat3;
  logic ramcs, ramwe, ramoe, ramlb, ramub;
  logic ramcs3, ramwe3, ramoe3, ramlb3, ramub3;
  logic [AW-1:0] adr, adr3;

  sram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(1)) u_dut (
    .clk(clk), .rst(rst), .RAMCS(ramcs), .RAMWE(ramwe), .RAMOE(ramoe),
    .RAMLB(ramlb), .RAMUB(ramub), .ADR(adr), .DAT(dat), .bus(bus)
  );

  sram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(3)) u3 (
    .clk(clk), .rst(rst), .RAMCS(ramcs3), .RAMWE(ramwe3), .RAMOE(ramoe3),
    .RAMLB(ramlb3), .RAMUB(ramub3), .ADR(adr3), .DAT(dat3), .bus(bus3)
  );

  // SRAM model: 256 words, drives when OE low and not writing.
  logic [DW-1:0] mem [0:255];
  assign dat = (!ramcs && !ramoe && ramwe) ? mem[adr[7:0]] : 'z;
  always @(negedge clk) begin
    if (!ramcs && !ramwe) begin
      if (!ramlb) mem[adr[7:0]][7:0]  <= dat[7:0];
      if (!ramub) mem[adr[7:0]][15:8] <= dat[15:8];
    end
  end

  assign dat3 = (!ramcs3 && !ramoe3) ? 16'hA5C3 : 'z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [AW-1:0] a,
                        input logic [1:0] s, input logic [DW-1:0] d);
    bus.ch_write[c]            = w;
    bus.ch_adr[c*AW +: AW]     = a;
    bus.ch_sel[c*2 +: 2]       = s;
    bus.ch_wdata[c*DW +: DW]   = d;
  endtask

  function automatic int ack_idx(input logic [2:0] a);
    case (a)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord [6];
    int got_n, last_t, cyc, gap;

    bus.ch_req = '0;  bus.ch_write = '0; bus.ch_adr = '0;
    bus.ch_sel = '0;  bus.ch_wdata = '0;
    bus3.ch_req = '0; bus3.ch_write = '0; bus3.ch_adr = '0;
    bus3.ch_sel = '0; bus3.ch_wdata = '0;

    rst = 1'b1;
    tick; tick;
    chk("rst_we",    32'(ramwe), 1);
    chk("rst_oe",    32'(ramoe), 0);
    chk("rst_lb",    32'(ramlb), 1);
    chk("rst_ub",    32'(ramub), 1);
    chk("rst_cs",    32'(ramcs), 0);
    chk("rst_adr",   32'(adr), 0);
    chk("rst_ack",   32'(bus.ch_ack), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst3_we",   32'(ramwe3), 1);
    chk("rst3_oe",   32'(ramoe3), 0);
    chk("rst3_lbub", 32'({ramlb3, ramub3, ramcs3}), 3'b110);
    chk("rst3_adr",  32'(adr3), 0);
    chk("rst3_busy", 32'(bus3.busy), 0);
    rst = 1'b0;
    tick;

    // Full write ch0
    set_ch(0, 1'b1, 18'h00012, 2'b11, 16'hBEEF);
    bus.ch_req[0] = 1'b1;
    tick;
    chk("wr_busy",  32'(bus.busy), 1);
    chk("wr_we",    32'(ramwe), 0);
    chk("wr_oe",    32'(ramoe), 1);
    chk("wr_adr",   32'(adr), 'h12);
    chk("wr_dat",   32'(dat), 'hBEEF);
    chk("wr_lbub",  32'({ramlb, ramub}), 0);
    chk("wr_noack", 32'(bus.ch_ack), 0);
    tick;
    chk("wr_ack",   32'(bus.ch_ack), 3'b001);
    chk("wr_we_up", 32'(ramwe), 1);
    chk("wr_hold",  32'(dat), 'hBEEF);
    bus.ch_req[0] = 1'b0;
    tick;
    chk("wr_ackclr", 32'(bus.ch_ack), 0);
    chk("wr_idle",   32'(bus.busy), 0);
    chk("wr_oe_lo",  32'(ramoe), 0);

    // Read back ch0
    set_ch(0, 1'b0, 18'h00012, 2'b11, 16'h0000);
    bus.ch_req[0] = 1'b1;
    tick;
    chk("rd_oe", 32'(ramoe), 0);
    chk("rd_we", 32'(ramwe), 1);
    tick;
    chk("rd_ack",   32'(bus.ch_ack), 3'b001);
    chk("rd_rdata", 32'(bus.rdata), 'hBEEF);
    bus.ch_req[0] = 1'b0;
    tick;

    // Upper-byte write ch1
    set_ch(1, 1'b1, 18'h00012, 2'b10, 16'h1234);
    bus.ch_req[1] = 1'b1;
    tick;
    chk("bw_ub", 32'(ramub), 0);
    chk("bw_lb", 32'(ramlb), 1);
    chk("bw_we", 32'(ramwe), 0);
    tick;
    chk("bw_ack", 32'(bus.ch_ack), 3'b010);
    bus.ch_req[1] = 1'b0;
    tick;
    set_ch(0, 1'b0, 18'h00012, 2'b11, 16'h0000);
    bus.ch_req[0] = 1'b1;
    tick; tick;
    chk("bw_rd_ack", 32'(bus.ch_ack), 3'b001);
    chk("bw_rdata",  32'(bus.rdata), 'h12EF);
    bus.ch_req[0] = 1'b0;
    tick;

    // Reset in the middle of a write
    set_ch(2, 1'b1, 18'h3FFFF, 2'b11, 16'h5555);
    bus.ch_req[2] = 1'b1;
    tick;
    chk("ra_we_lo", 32'(ramwe), 0);
    rst = 1'b1;
    #1;
    chk("ra_we",   32'(ramwe), 1);
    chk("ra_ack",  32'(bus.ch_ack), 0);
    chk("ra_adr",  32'(adr), 0);
    chk("ra_busy", 32'(bus.busy), 0);
    chk("ra_drv",  32'(u_dut.drv), 0);
    bus.ch_req[2] = 1'b0;
    tick; tick;
    chk("ra_ack2", 32'(bus.ch_ack), 0);
    rst = 1'b0;
    tick;
    chk("ra_noack", 32'(bus.ch_ack), 0);

    // All three requesting continuously
`ifdef SRAM_ARB_RR_EN
    exp_ord = '{0, 1, 2, 0, 1, 2};
`else
    exp_ord = '{2, 2, 2, 2, 2, 2};
`endif
    set_ch(0, 1'b0, 18'h00100, 2'b11, 16'h0);
    set_ch(1, 1'b0, 18'h00101, 2'b11, 16'h0);
    set_ch(2, 1'b0, 18'h00102, 2'b11, 16'h0);
    bus.ch_req = 3'b111;
    got_n = 0; last_t = -1; cyc = 0;
    while (got_n < 6 && cyc < 60) begin
      tick;
      cyc++;
      if (bus.ch_ack != 3'b000) begin
        chk($sformatf("arb%0d", got_n), ack_idx(bus.ch_ack), exp_ord[got_n]);
        if (last_t >= 0) chk("arb_gap", cyc - last_t, 3);
        last_t = cyc;
        got_n++;
      end
    end
    chk("arb_count", got_n, 6);
    bus.ch_req = '0;
    tick; tick;

    // WAIT=3 read, then back-to-back
    bus3.ch_adr[AW-1:0] = 18'h00155;
    bus3.ch_sel[1:0]    = 2'b11;
    bus3.ch_req[0]      = 1'b1;
    tick;
    chk("w3_adr0", 32'(adr3), 'h155);
    chk("w3_ack0", 32'(bus3.ch_ack), 0);
    tick;
    chk("w3_adr1", 32'(adr3), 'h155);
    chk("w3_ack1", 32'(bus3.ch_ack), 0);
    tick;
    chk("w3_adr2", 32'(adr3), 'h155);
    chk("w3_ack2", 32'(bus3.ch_ack), 0);
    tick;
    chk("w3_ack",   32'(bus3.ch_ack), 3'b001);
    chk("w3_rdata", 32'(bus3.rdata), 'hA5C3);
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (bus3.ch_ack != 3'b000) begin
        gap = i;
        break;
      end
    end
    chk("w3_b2b", gap, 5);
    bus3.ch_req = '0;
    tick; tick;

    // Random traffic: one-hot acks, no spurious acks, no bus contention
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!bus.ch_req[c] && $urandom_range(0, 3) == 0) begin
          set_ch(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), DW'($urandom));
          bus.ch_req[c] = 1'b1;
        end
      end
      tick;
      chk("rnd_onehot",  32'(bus.ch_ack & (bus.ch_ack - 3'd1)), 0);
      chk("rnd_spur",    32'(bus.ch_ack & ~bus.ch_req), 0);
      chk("rnd_contend", 32'(u_dut.drv & ~ramoe), 0);
      bus.ch_req = bus.ch_req & ~bus.ch_ack;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
